display_scan_ctrl: RTL and testbench

Parametrised, time-multiplexed multi-digit seven-segment controller for the up/down guessing game. It scans NUM_DIGITS common-enable digits. Digit 0 shows the game result symbol (WIN/UP/DOWN), and the remaining digits show hex nibbles such as the attempt count. On game over, every digit blinks the game_status pattern. Updates are double-buffered and applied only at frame boundaries, so the display never tears mid-scan. It sits between the game FSM and the board's segment and anode pins.

---
 rtl/display_pkg.sv | 33 +++
 rtl/display_scan_ctrl_if.sv | 24 ++
 rtl/display_scan_ctrl_hex.sv | 11 +
 rtl/display_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants for the seven-segment scan controller: result codes,
// result symbols and the hex digit segment table ({a,b,c,d,e,f,g}, active-high).
package display_pkg;

  typedef enum logic [1:0] {
    RES_WIN  = 2'b00,
    RES_UP   = 2'b01,
    RES_DOWN = 2'b10,
    RES_NONE = 2'b11
  } result_e;

  localparam logic [6:0] SYM_WIN   = 7'b0000001;
  localparam logic [6:0] SYM_UP    = 7'b1000001;
  localparam logic [6:0] SYM_DOWN  = 7'b1000010;
  localparam logic [6:0] SYM_BLANK = 7'b0000000;

  localparam logic [6:0] HEX_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic [6:0] result_symbol(input result_e res);
    case (res)
      RES_WIN:  return SYM_WIN;
      RES_UP:   return SYM_UP;
      RES_DOWN: return SYM_DOWN;
      default:  return SYM_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bundle between the game FSM (master) and the display scan controller (slave),
// including the board-facing segment/anode drive and the frame pulse.
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                          update;
  logic [1:0]                    result;
  logic [4*(NUM_DIGITS-1)-1:0]   digit_data;
  logic                          game_over;
  logic [6:0]                    game_status;
  logic [6:0]                    seg;
  logic [NUM_DIGITS-1:0]         an;
  logic                          frame_done;

  modport master (
    output update, result, digit_data, game_over, game_status,
    input  seg, an, frame_done
  );

  modport slave (
    input  update, result, digit_data, game_over, game_status,
    output seg, an, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl_hex.sv
// Combinational nibble-to-segment decoder driven by the shared hex table.
module seg_hex_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = HEX_TABLE[nibble];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with frame-aligned double buffering
// and a game-over blink mode.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 64,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  display_scan_ctrl_if.slave bus
);

  localparam int DATA_W  = 4 * (NUM_DIGITS - 1);
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCAN_W-1:0]     SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0]    BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] AN_FIRST   = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] AN_RESET   = (ACTIVE_LOW != 0) ? ~AN_FIRST : AN_FIRST;
  localparam logic [6:0]            SEG_RESET  = (ACTIVE_LOW != 0) ? ~SYM_BLANK : SYM_BLANK;

  logic [SCAN_W-1:0]     scan_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic                  scan_last;
  logic                  wrap;
  logic                  wrap_d;

  logic                  pending;
  result_e               shadow_result;
  logic [DATA_W-1:0]     shadow_data;
  result_e               active_result;
  logic [DATA_W-1:0]     active_data;

  logic [BLINK_W-1:0]    blink_cnt;
  logic                  blink_phase;
  logic                  game_over_d;

  logic [3:0]            cur_nibble;
  logic [6:0]            hex_pattern;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  frame_done_q;

  assign scan_last = (scan_cnt == SCAN_LAST);
  assign wrap      = scan_last && (digit_idx == IDX_LAST);

  // NOTE: sequential state uses non-blocking assignments and a synchronous
  // reset tested first inside the clocked block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_last) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      scan_cnt  <= scan_cnt + SCAN_W'(1);
    end
  end

  // NOTE: shadow payload has no reset; it is only observed while pending is set,
  // and pending is cleared by reset.
  always_ff @(posedge clk) begin
    if (bus.update) begin
      shadow_result <= result_e'(bus.result);
      shadow_data   <= bus.digit_data;
    end
  end

  // An update landing exactly on the wrap bypasses the shadow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending       <= 1'b0;
      active_result <= RES_NONE;
      active_data   <= '0;
    end else if (wrap) begin
      if (bus.update) begin
        active_result <= result_e'(bus.result);
        active_data   <= bus.digit_data;
      end else if (pending) begin
        active_result <= shadow_result;
        active_data   <= shadow_data;
      end
      pending <= 1'b0;
    end else if (bus.update) begin
      pending <= 1'b1;
    end
  end

  // Blink state is parked at "visible, count 0" outside game over and on its rising edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      game_over_d <= 1'b0;
    end else begin
      game_over_d <= bus.game_over;
      if (!bus.game_over || !game_over_d) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (wrap) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt   <= blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    cur_nibble = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) cur_nibble = active_data[4*(i-1) +: 4];
    end
  end

  seg_hex_decoder u_hex (
    .nibble  (cur_nibble),
    .pattern (hex_pattern)
  );

  always_comb begin
    seg_next = SYM_BLANK;
    if (bus.game_over) begin
      seg_next = blink_phase ? bus.game_status : SYM_BLANK;
    end else if (digit_idx == '0) begin
      seg_next = result_symbol(active_result);
    end else begin
      seg_next = hex_pattern;
    end
    an_next = AN_FIRST << digit_idx;
  end

  // frame_done is delayed to line up with the first registered digit-0 output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_q        <= SEG_RESET;
      an_q         <= AN_RESET;
      wrap_d       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= (ACTIVE_LOW != 0) ? ~seg_next : seg_next;
      an_q         <= (ACTIVE_LOW != 0) ? ~an_next : an_next;
      wrap_d       <= wrap;
      frame_done_q <= wrap_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: hand-derived checkpoints for the
// directed scenarios plus a frame-arithmetic reference model under random stimulus.
module tb_display_scan_ctrl;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int BD    = 2;
  localparam int FRAME = ND * SD;
  localparam logic [6:0] GS = 7'b0110111;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  display_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  display_scan_ctrl #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD),
    .ACTIVE_LOW (0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;   // clock edges since reset release

  logic [6:0] hex_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Reference model state: frame position is derived from k arithmetically.
  logic        m_pending;
  logic [1:0]  m_sh_res, m_act_res;
  logic [11:0] m_sh_data, m_act_data;
  logic        m_go_prev;
  int          m_wraps;
  logic [6:0]  m_seg;
  logic [3:0]  m_an;
  logic        m_fd;

  logic        cur_go;
  logic [1:0]  cur_res;
  logic [11:0] cur_data;
  logic [6:0]  cur_gs;

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } cp_t;

  cp_t cp [11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, k, got, exp);
    end
  endtask

  function automatic logic [6:0] sym(input logic [1:0] r);
    case (r)
      2'b00:   return 7'b0000001;
      2'b01:   return 7'b1000001;
      2'b10:   return 7'b1000010;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic model_reset();
    m_pending  = 1'b0;
    m_act_res  = 2'b11;
    m_act_data = 12'h000;
    m_go_prev  = 1'b0;
    m_wraps    = 0;
    k          = 0;
  endtask

  task automatic model_edge(input logic u, input logic [1:0] r, input logic [11:0] d,
                            input logic go, input logic [6:0] gs);
    int   digit;
    logic wrap;
    logic visible;
    digit   = (k / SD) % ND;
    wrap    = (k % FRAME) == FRAME - 1;
    visible = ((m_wraps / BD) % 2) == 0;
    if (go)              m_seg = visible ? gs : 7'b0000000;
    else if (digit == 0) m_seg = sym(m_act_res);
    else                 m_seg = hex_tab[4'((m_act_data >> (4 * (digit - 1))) & 12'hF)];
    m_an = 4'(1 << digit);
    m_fd = (k > 0) && (k % FRAME == 0);
    if (wrap) begin
      if (u)              begin m_act_res = r;        m_act_data = d;         end
      else if (m_pending) begin m_act_res = m_sh_res; m_act_data = m_sh_data; end
      m_pending = 1'b0;
    end else if (u) begin
      m_pending = 1'b1;
    end
    if (u) begin m_sh_res = r; m_sh_data = d; end
    if (!go || !m_go_prev) m_wraps = 0;
    else if (wrap)         m_wraps++;
    m_go_prev = go;
    k++;
  endtask

  task automatic step(input logic u, input logic [1:0] r, input logic [11:0] d,
                      input logic go, input logic [6:0] gs);
    cur_res = r; cur_data = d; cur_go = go; cur_gs = gs;
    bus.update = u; bus.result = r; bus.digit_data = d;
    bus.game_over = go; bus.game_status = gs;
    @(posedge clk);
    model_edge(u, r, d, go, gs);
    #1;
    check("model_seg", 32'(bus.seg), 32'(m_seg));
    check("model_an", 32'(bus.an), 32'(m_an));
    check("model_frame_done", 32'(bus.frame_done), 32'(m_fd));
    bus.update = 1'b0;
  endtask

  task automatic run_until(input int target);
    while (k < target) step(1'b0, cur_res, cur_data, cur_go, cur_gs);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    bus.update = 1'b0;
    @(posedge clk);
    #1;
    check("reset_seg", 32'(bus.seg), 32'h00);
    check("reset_an", 32'(bus.an), 32'h1);
    check("reset_frame_done", 32'(bus.frame_done), 32'h0);
    check("reset_pending", 32'(dut.pending), 32'h0);
    model_reset();
    reset_n = 1'b1;
  endtask

  initial begin
    cp[0]  = '{1,  4'b0001, 7'b0000000, 1'b0};
    cp[1]  = '{5,  4'b0010, 7'b1111110, 1'b0};
    cp[2]  = '{9,  4'b0100, 7'b1111110, 1'b0};
    cp[3]  = '{13, 4'b1000, 7'b1111110, 1'b0};
    cp[4]  = '{16, 4'b1000, 7'b1111110, 1'b0};
    cp[5]  = '{17, 4'b0001, 7'b1000001, 1'b1};
    cp[6]  = '{18, 4'b0001, 7'b1000001, 1'b0};
    cp[7]  = '{21, 4'b0010, 7'b1011011, 1'b0};
    cp[8]  = '{25, 4'b0100, 7'b1110111, 1'b0};
    cp[9]  = '{29, 4'b1000, 7'b1111001, 1'b0};
    cp[10] = '{33, 4'b0001, 7'b1000001, 1'b1};

    bus.update = 1'b0; bus.result = 2'b00; bus.digit_data = '0;
    bus.game_over = 1'b0; bus.game_status = '0;
    cur_go = 1'b0; cur_res = 2'b00; cur_data = 12'h000; cur_gs = 7'h00;
    m_sh_res = 2'b11; m_sh_data = 12'h000;

    do_reset();

    // Scan order and buffered update issued mid-frame.
    begin
      int j = 0;
      for (int e = 1; e <= 33; e++) begin
        step(e == 6, 2'b01, 12'h3A5, 1'b0, 7'h00);
        if (j < 11 && cp[j].k == k) begin
          check("table_an", 32'(bus.an), 32'(cp[j].an));
          check("table_seg", 32'(bus.seg), 32'(cp[j].seg));
          check("table_frame_done", 32'(bus.frame_done), 32'(cp[j].fd));
          j++;
        end
      end
    end

    // Two updates in one frame: the later one is shown.
    run_until(39);
    step(1'b1, 2'b00, 12'h3A5, 1'b0, 7'h00);
    run_until(43);
    step(1'b1, 2'b10, 12'h3A5, 1'b0, 7'h00);
    run_until(49);
    check("last_wins_seg", 32'(bus.seg), 32'b1000010);
    check("last_wins_an", 32'(bus.an), 32'b0001);
    check("last_wins_frame_done", 32'(bus.frame_done), 32'h1);

    // Update on the exact wrap cycle.
    run_until(63);
    step(1'b1, 2'b00, 12'h3A5, 1'b0, 7'h00);
    check("bypass_pending", 32'(dut.pending), 32'h0);
    step(1'b0, 2'b00, 12'h3A5, 1'b0, 7'h00);
    check("bypass_seg", 32'(bus.seg), 32'b0000001);

    // Blink: two frames on, two frames off, then immediate restore.
    run_until(69);
    for (int e = 70; e <= 129; e++) begin
      step(1'b0, 2'b00, 12'h3A5, 1'b1, GS);
      if (k == 70 || k == 96 || k == 129) check("blink_on", 32'(bus.seg), 32'(GS));
      if (k == 97 || k == 128) check("blink_off", 32'(bus.seg), 32'h00);
    end
    step(1'b0, 2'b00, 12'h3A5, 1'b0, GS);
    check("blink_restore", 32'(bus.seg), 32'b0000001);

    // Reset in blink mode with an update pending.
    for (int e = 131; e <= 140; e++) step(e == 138, 2'b01, 12'hFFF, 1'b1, GS);
    check("pre_reset_pending", 32'(dut.pending), 32'h1);
    do_reset();
    cur_go = 1'b0;
    run_until(17);
    check("post_reset_digit0", 32'(bus.seg), 32'h00);
    check("post_reset_frame_done", 32'(bus.frame_done), 32'h1);
    run_until(21);
    check("post_reset_digit1", 32'(bus.seg), 32'b1111110);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic go;
      go = cur_go;
      if ($urandom_range(63) == 0) go = ~go;
      step($urandom_range(7) == 0, 2'($urandom_range(3)), 12'($urandom),
           go, 7'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
